// File: rtl/mem_ram_rssb_if.sv
// Request/response bus between the RSSB core sequencer (master) and its data RAM (slave).
// A request is taken on req_valid && req_ready; a response completes on rsp_valid && rsp_ready.
interface mem_ram_rssb_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rdata;
    logic              borrow;
    logic              err;

    modport master (
        output req_valid, op, address, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, borrow, err
    );

    modport slave (
        input  req_valid, op, address, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, borrow, err
    );
endinterface

// File: rtl/mem_ram_rssb.sv
// Windowed data RAM for the RSSB core: read, write and atomic mem = mem - acc with borrow.
// One request in flight; each request walks IDLE -> ACCESS -> RESP.
module mem_ram_rssb #(
    parameter int                     WIDTH    = 8,
    parameter int                     ADDR_W   = 8,
    parameter int                     DEPTH    = 4,
    parameter logic [DEPTH*WIDTH-1:0] INIT_VEC = 32'h04080201
) (
    input  logic          clk,
    input  logic          rst,
    mem_ram_rssb_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RSSB  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t            state;
    state_t            state_nxt;
    op_t               cap_op;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_hit;
    logic [WIDTH-1:0]  cap_wdata;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [WIDTH:0]    sub_ext;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  res_rdata;
    logic              res_borrow;
    logic              res_err;

    // Window bits between the index and the select bit alias the array.
    if (IDX_W < ADDR_W - 1) begin : g_alias
        logic unused_alias;
        assign unused_alias = ^bus.address[ADDR_W-2:IDX_W];
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ACCESS;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_op    <= OP_READ;
            cap_idx   <= '0;
            cap_hit   <= 1'b0;
            cap_wdata <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            cap_op    <= op_t'(bus.op);
            cap_idx   <= bus.address[IDX_W-1:0];
            cap_hit   <= bus.address[ADDR_W-1];
            cap_wdata <= bus.wdata;
        end
    end

    // The extra top bit of the widened subtraction is the unsigned borrow.
    always_comb begin
        sub_ext    = {1'b0, mem[cap_idx]} - {1'b0, cap_wdata};
        wr_en      = 1'b0;
        wr_data    = cap_wdata;
        res_rdata  = '0;
        res_borrow = 1'b0;
        res_err    = 1'b1;
        if (cap_hit) begin
            case (cap_op)
                OP_READ: begin
                    res_rdata = mem[cap_idx];
                    res_err   = 1'b0;
                end
                OP_WRITE: begin
                    wr_en     = 1'b1;
                    res_rdata = cap_wdata;
                    res_err   = 1'b0;
                end
                OP_RSSB: begin
                    wr_en      = 1'b1;
                    wr_data    = sub_ext[WIDTH-1:0];
                    res_rdata  = sub_ext[WIDTH-1:0];
                    res_borrow = sub_ext[WIDTH];
                    res_err    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is reset on purpose; reset must restore the init image, so it maps to flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VEC[i*WIDTH +: WIDTH];
        end else if (state == ACCESS && wr_en) begin
            mem[cap_idx] <= wr_data;
        end
    end

    // Response fields are loaded only at the ACCESS edge and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata  <= '0;
            bus.borrow <= 1'b0;
            bus.err    <= 1'b0;
        end else if (state == ACCESS) begin
            bus.rdata  <= res_rdata;
            bus.borrow <= res_borrow;
            bus.err    <= res_err;
        end
    end
endmodule

// File: doc/mem_ram_rssb.md
Name: mem_ram_rssb

Overview:
- Parametrised, memory-mapped data RAM for the RSSB core. Generalises the fixed four-word store to DEPTH words of WIDTH bits, each with its own reset-time init value.
- Adds a valid/ready request/response interface and an atomic RSSB read-modify-write operation: mem = mem − acc, with a borrow flag for the skip decision.
- Sits between the core sequencer and the data address space. It responds only to addresses inside its window.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 8, address width. The window is selected by address[ADDR_W-1] = 1.
- DEPTH, 4, number of words. Must be a power of two, ≥ 2 and ≤ 2^(ADDR_W-1). IDX_W = log2(DEPTH).
- INIT_VEC, 32'h04080201, DEPTH*WIDTH-bit reset image. Word i is INIT_VEC[i*WIDTH +: WIDTH].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- op  in  2  operation: 00 read, 01 write, 10 rssb, 11 reserved.
- address  in  ADDR_W  word address.
- wdata  in  WIDTH  write data (write) or accumulator (rssb).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rdata  out  WIDTH  read data, or subtraction result for rssb.
- borrow  out  1  rssb borrow: mem < acc, unsigned.
- err  out  1  request was out-of-window or used the reserved op.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - Every word i = INIT_VEC word i.
  - rsp_valid=0, rdata=0, borrow=0, err=0.
  - req_ready=1. It is decoded from state and is 1 during reset.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture op, index = address[IDX_W-1:0], hit = address[ADDR_W-1], and wdata; go to ACCESS. With req_valid=0, stay in IDLE.
  - ACCESS: one cycle, req_ready=0. Execute the captured op (below), register rdata/borrow/err, and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rdata, borrow and err are held stable. When rsp_ready=1, go to IDLE.
- Latency and throughput:
  - A request accepted at edge N gives rsp_valid=1 from edge N+2.
  - The earliest next acceptance is the edge after the response handshake, so at most one request is in flight.
- Operations in ACCESS (only when hit=1):
  - read: rdata = mem[index], borrow=0, err=0.
  - write: mem[index] = wdata at the ACCESS edge. rdata = wdata, borrow=0, err=0.
  - rssb:
    - diff = (mem[index] − wdata) mod 2^WIDTH.
    - mem[index] = diff at the same edge (atomic; no other access can intervene).
    - rdata = diff.
    - borrow = (mem[index] < wdata) using the pre-write value, unsigned.
    - err=0.
  - reserved (op 11): no memory change, rdata=0, borrow=0, err=1.
- Out-of-window request (hit=0): no memory change for any op, rdata=0, borrow=0, err=1. A response is still produced.
- Index wrap: only the low IDX_W address bits index the array. Bits between IDX_W and ADDR_W-2 are ignored, so the array aliases within the window.
- Read-after-write: a request accepted after a write/rssb response sees the updated value. There is no stale data.
- Memory changes only at the ACCESS edge. No write occurs in IDLE or RESP.
- Reset mid-operation:
  - An in-flight request is discarded and no response is produced.
  - Memory returns to INIT_VEC, including the target of a write/rssb whose ACCESS edge had not yet occurred.
  - A word written at an earlier edge is also reinitialised.
- Inputs are ignored outside IDLE. They may change freely in ACCESS and RESP.

Test Plan:
- Reset, then read 0x80, 0x81, 0x82, 0x83 (rsp_ready=1) -> rdata 0x01, 0x02, 0x08, 0x04; err=0, borrow=0; each rsp_valid exactly 2 cycles after acceptance.
- Write 0x81 ← 0x55, then read 0x81 -> write response rdata=0x55; read rdata=0x55; other words unchanged.
- rssb 0x82 acc=0x03 -> rdata=0x05, borrow=0, then read 0x82 = 0x05. rssb 0x80 acc=0x09 -> rdata=0xF8, borrow=1, then read 0x80 = 0xF8.
- Write 0x05 ← 0xAA, and op=11 at 0x80 -> both responses err=1, rdata=0; full read-back equals the init image.
- Hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid=1, req_ready=0, rdata/borrow stable; a req_valid pulse in that time is not accepted; rsp_ready=1 -> IDLE next edge.
- Write 0x83 ← 0xFF; assert rst asynchronously during ACCESS -> rsp_valid=0 immediately, state IDLE, read 0x83 after reset = 0x04.
- DEPTH=8, WIDTH=16 instance: rssb at 0x87 and at aliased 0x8F hit word 7; borrow computed on 16 bits (0x0000 − 0x0001 -> 0xFFFF, borrow=1).
